// File: rtl/array_search_pkg.sv
// Shared types for the array search engine.
//  mode_t  : search operation selected at start
//  state_t : engine control state
package array_search_pkg;

  typedef enum logic [1:0] {
    INDEX_FIRST   = 2'd0,
    INDEX_LAST    = 2'd1,
    COUNT_LESS    = 2'd2,
    COUNT_GREATER = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/array_search_cmp.sv
// Combinational element comparator for the array search engine.
// Ports:
//  mode  in  search mode
//  data  in  heap element being examined
//  key   in  search value
//  hit   out data equals key
//  inc   out count increment for the COUNT_* modes (unsigned compare)
module array_search_cmp
  import array_search_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] key,
  output logic             hit,
  output logic             inc
);

  always_comb begin
    hit = (data == key);
    inc = 1'b0;
    case (mode)
      COUNT_LESS:    inc = (data < key);
      COUNT_GREATER: inc = (data > key);
      default:       inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/array_search_engine.sv
// Multi-cycle array search engine. Scans one heap array area through a
// synchronous read port (1-cycle latency), one element per cycle, and
// reports a first/last match index (1-based, 0 = none) or a less/greater count.
// Ports:
//  clock, reset         rising-edge clock, synchronous active-high reset
//  start                request, accepted only while ready=1
//  mode, array, size,   operation, array number, array length (clamped to
//  key                  NAREA) and search value, latched at acceptance
//  ready                engine can accept start
//  mem_rd_en/addr       heap read strobe and address (array*NAREA + element)
//  mem_rd_data          read data, valid the cycle after mem_rd_en
//  done                 one-cycle pulse, result valid
//  result               index or count, held until the next acceptance
module array_search_engine
  import array_search_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int NAREA   = 4,
  parameter int NARRAYS = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [1:0]                         mode,
  input  logic [$clog2(NARRAYS)-1:0]         array,
  input  logic [WIDTH-1:0]                   size,
  input  logic [WIDTH-1:0]                   key,
  output logic                               ready,
  output logic                               mem_rd_en,
  output logic [$clog2(NARRAYS*NAREA)-1:0]   mem_rd_addr,
  input  logic [WIDTH-1:0]                   mem_rd_data,
  output logic                               done,
  output logic [WIDTH-1:0]                   result
);

  localparam int AW  = $clog2(NARRAYS*NAREA);
  localparam int ARW = $clog2(NARRAYS);
  localparam int CW  = $clog2(NAREA+1);

  state_t             state, state_next;
  mode_t              mode_reg;
  logic [ARW-1:0]     array_reg;
  logic [WIDTH-1:0]   key_reg;
  logic [CW-1:0]      n_reg;
  logic [CW-1:0]      idx_reg;       // next element to issue
  logic [CW-1:0]      rd_idx_reg;    // element whose data arrives this cycle
  logic               rd_valid_reg;  // a read was issued last cycle
  logic [WIDTH-1:0]   result_reg;

  logic               accept;
  logic               cmp_en;
  logic               cmp_hit;
  logic               cmp_inc;
  logic               first_hit;
  logic [CW-1:0]      n_clamped;

  assign n_clamped = (size > WIDTH'(NAREA)) ? CW'(NAREA) : CW'(size);

  array_search_cmp #(.WIDTH(WIDTH)) u_cmp (
    .mode (mode_reg),
    .data (mem_rd_data),
    .key  (key_reg),
    .hit  (cmp_hit),
    .inc  (cmp_inc)
  );

  // Returned data is only meaningful while scanning; reset clears
  // rd_valid_reg so data from an aborted scan is never looked at.
  assign cmp_en    = rd_valid_reg && ((state == SCAN) || (state == DRAIN));
  assign first_hit = cmp_en && cmp_hit && (mode_reg == INDEX_FIRST);

  assign result = result_reg;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    ready       = 1'b0;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        // A first-match hit suppresses the read being issued in the same
        // cycle, so nothing beyond the matching element is fetched.
        if (first_hit || (n_reg == '0)) begin
          state_next = DONE;
        end else begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = AW'(AW'(array_reg) * AW'(NAREA) + AW'(idx_reg));
          if (idx_reg == n_reg - CW'(1)) state_next = DRAIN;
        end
      end
      DRAIN: state_next = DONE;  // compare of the last issued element
      DONE: begin
        done  = 1'b1;
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SCAN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_reg     <= INDEX_FIRST;
      array_reg    <= '0;
      key_reg      <= '0;
      n_reg        <= '0;
      idx_reg      <= '0;
      rd_idx_reg   <= '0;
      rd_valid_reg <= 1'b0;
      result_reg   <= '0;
    end else begin
      rd_valid_reg <= mem_rd_en;
      rd_idx_reg   <= idx_reg;
      if (accept) begin
        mode_reg   <= mode_t'(mode);
        array_reg  <= array;
        key_reg    <= key;
        n_reg      <= n_clamped;
        idx_reg    <= '0;
        result_reg <= '0;
      end else begin
        if (mem_rd_en) idx_reg <= idx_reg + CW'(1);
        if (cmp_en) begin
          case (mode_reg)
            INDEX_FIRST, INDEX_LAST: begin
              if (cmp_hit) result_reg <= WIDTH'(rd_idx_reg) + WIDTH'(1);
            end
            COUNT_LESS, COUNT_GREATER: begin
              result_reg <= result_reg + WIDTH'(cmp_inc);
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_array_search_engine.sv
module tb_array_search_engine;

  localparam int WIDTH   = 12;
  localparam int NAREA   = 4;
  localparam int NARRAYS = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode  = 2'd0;
  logic [1:0]  array = 2'd0;
  logic [11:0] size  = 12'd0;
  logic [11:0] key   = 12'd0;
  logic        ready;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [11:0] mem_rd_data;
  logic        done;
  logic [11:0] result;

  logic [11:0] heap [16];
  int          rd_count = 0;
  int          total = 0;
  int          bad   = 0;

  always #5 clock = ~clock;

  array_search_engine #(.WIDTH(WIDTH), .NAREA(NAREA), .NARRAYS(NARRAYS)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .array       (array),
    .size        (size),
    .key         (key),
    .ready       (ready),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .done        (done),
    .result      (result)
  );

  // Heap with 1-cycle read latency; junk on the bus when no read was issued.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= heap[mem_rd_addr];
    else           mem_rd_data <= 12'($urandom);
    if (mem_rd_en) rd_count <= rd_count + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // Per-cycle reference: on acceptance, compute from the heap contents what
  // the whole transaction must look like (read schedule, done cycle, result).
  task automatic monitor();
    int c = 0;
    bit busy = 0;
    int t_acc = 0, done_off = 0, reads = 0, base = 0;
    int exp_res = 0, last_res = 0;
    forever begin
      bit exp_ready, exp_done, exp_rd;
      int rel;
      @(negedge clock);
      c++;
      if (reset) begin
        busy = 0;
        last_res = 0;
        continue;
      end
      rel = c - t_acc;
      if (busy) begin
        exp_rd    = (rel >= 1) && (rel <= reads);
        exp_done  = (rel == done_off);
        exp_ready = exp_done;
      end else begin
        exp_rd = 0; exp_done = 0; exp_ready = 1;
      end
      check("ready", ready, exp_ready);
      check("done", done, exp_done);
      check("rd_en", mem_rd_en, exp_rd);
      if (exp_rd) check("rd_addr", mem_rd_addr, base + rel - 1);
      if (exp_done) begin
        last_res = exp_res;
        busy = 0;
      end
      if (!busy) check("result", result, last_res);
      if (exp_ready && start) begin
        int n;
        n = (size > NAREA) ? NAREA : int'(size);
        base = int'(array) * NAREA;
        exp_res = 0; reads = n; done_off = n + 2;
        for (int i = 0; i < n; i++) begin
          logic [11:0] d;
          d = heap[base + i];
          if (mode == 2'd0 && d == key) begin
            exp_res = i + 1; reads = i + 1; done_off = i + 3;
            break;
          end
          if (mode == 2'd1 && d == key) exp_res = i + 1;
          if (mode == 2'd2 && d < key) exp_res++;
          if (mode == 2'd3 && d > key) exp_res++;
        end
        busy = 1;
        t_acc = c;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives a one-cycle start once ready; returns one cycle after acceptance.
  task automatic issue(input int m, input int arr, input int sz, input int k);
    int w = 0;
    while (!ready && w < 20) begin tick(); w++; end
    if (!ready) check("ready_timeout", 0, 1);
    mode = 2'(m); array = 2'(arr); size = 12'(sz); key = 12'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 50) begin tick(); lat++; end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input string nm, input int m, input int arr, input int sz, input int k,
                        input int exp_r, input int exp_lat, input int exp_reads);
    int lat, r0;
    r0 = rd_count;
    issue(m, arr, sz, k);
    wait_done(1, lat);
    check({nm, "_lat"}, lat, exp_lat);
    check({nm, "_res"}, result, exp_r);
    check({nm, "_reads"}, rd_count - r0, exp_reads);
  endtask

  function automatic logic [11:0] rand_val();
    if ($urandom_range(0, 3) == 0) return 12'hFF0 + 12'($urandom_range(0, 15));
    return 12'($urandom_range(0, 7));
  endfunction

  initial begin
    int lat;
    int vals [16] = '{10, 20, 30, 555, 10, 20, 30, 40, 20, 5, 20, 7, 1, 2, 3, 4};
    for (int i = 0; i < 16; i++) heap[i] = 12'(vals[i]);
    fork
      monitor();
    join_none

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_rd_addr, 0);
    check("rst_result", result, 0);

    run_op("first_hit", 0, 0, 3, 20, 2, 4, 2);
    run_op("last_hit", 1, 2, 4, 20, 3, 6, 4);

    // Back-to-back: second start in the done cycle of the first.
    issue(2, 1, 4, 25);
    wait_done(1, lat);
    check("cnt_less_lat", lat, 6);
    check("cnt_less_res", result, 2);
    issue(3, 1, 4, 25);
    check("b2b_ready_low", ready, 0);
    wait_done(1, lat);
    check("cnt_gt_lat", lat, 6);
    check("cnt_gt_res", result, 2);

    run_op("size0", 0, 1, 0, 10, 0, 2, 0);
    run_op("size9", 2, 3, 9, 3, 2, 6, 4);

    // Absent key with a start pulse at T+2 that must be ignored.
    issue(0, 0, 3, 99);
    tick();
    mode = 2'd2; array = 2'd1; size = 12'd4; key = 12'd25; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3, lat);
    check("absent_lat", lat, 5);
    check("absent_res", result, 0);
    tick();
    check("ignored_start_idle", ready, 1);
    check("ignored_start_done", done, 0);

    // Reset at T+2 of a scan.
    issue(3, 2, 4, 6);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_rd_en", mem_rd_en, 0);
    run_op("after_rst", 1, 3, 4, 4, 4, 6, 4);

    // Randomized phases; the monitor checks every cycle.
    for (int ph = 0; ph < 3; ph++) begin
      start = 1'b0;
      repeat (10) tick();
      for (int i = 0; i < 16; i++) heap[i] = rand_val();
      for (int cyc = 0; cyc < 300; cyc++) begin
        start = ($urandom_range(0, 2) == 0);
        mode  = 2'($urandom_range(0, 3));
        array = 2'($urandom_range(0, 3));
        size  = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 6));
        key   = rand_val();
        reset = ($urandom_range(0, 59) == 0);
        tick();
      end
      reset = 1'b0;
    end
    start = 1'b0;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
